// File: rtl/a78_loader.sv
// a78_loader: takes a byte stream from the download interface and routes it
// into cart RAM or BIOS RAM. For cart files it also decodes the A78 header
// and computes the payload size.
// Optional feature: define A78_SIZE_CHECK_EN to latch the header size field
// (bytes 49..52) and compare it with the measured payload (size_mismatch).
module a78_loader (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  output logic        cart_wr,
  output logic [17:0] cart_waddr,
  output logic [7:0]  cart_wdata,
  output logic        bios_wr,
  output logic [11:0] bios_waddr,
  output logic [7:0]  bios_wdata,
  output logic        cart_is_7800,
  output logic [31:0] cart_size,
  output logic [15:0] cart_flags,
  output logic [7:0]  joy0_type,
  output logic [7:0]  joy1_type,
  output logic [7:0]  cart_region,
  output logic [7:0]  cart_save,
  output logic        load_busy,
  output logic        load_done,
  output logic        initial_pause,
  output logic        addr_ovf
`ifdef A78_SIZE_CHECK_EN
  ,
  output logic        size_mismatch
`endif
);

  typedef enum logic [1:0] {IDLE, CART, BIOS, FINISH} state_t;

  state_t      state_q;
  logic        dl_q;
  logic        pend_q;
  logic        pend_cart_q;
  logic        hdr_ok_q;
  logic        seen_q;
  logic [24:0] last_q;
  logic        cart_wr_q, bios_wr_q, is7800_q, done_q, pause_q, ovf_q;
  logic [17:0] cart_waddr_q;
  logic [7:0]  cart_wdata_q, bios_wdata_q;
  logic [11:0] bios_waddr_q;
  logic [31:0] size_q;
  logic [15:0] flags_q;
  logic [7:0]  joy0_q, joy1_q, region_q, save_q;
`ifdef A78_SIZE_CHECK_EN
  logic [31:0] hdr_size_q;
  logic        mismatch_q;
`endif

  logic        rise;
  logic        start_cart;
  logic [24:0] eff_addr;
  logic        in_range;
  logic [31:0] size_d;

  // Edge detect, cart address translation and payload size computation.
  always_comb begin
    rise       = ioctl_download & ~dl_q;
    start_cart = pend_q ? pend_cart_q : (ioctl_index != 8'd0);
    eff_addr   = (is7800_q && (ioctl_addr >= 25'd128)) ? (ioctl_addr - 25'd128) : ioctl_addr;
    in_range   = (eff_addr[24:18] == '0);
    size_d     = '0;
    if (seen_q) begin
      if (!is7800_q)
        size_d = {7'd0, last_q} + 32'd1;
      else if (last_q >= 25'd128)
        size_d = {7'd0, last_q} - 32'd127;
    end
  end

  // Load FSM together with the registered write ports and header decode.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      // Seed the edge detector with the live level so an interrupted
      // download is ignored until the next genuine rising edge.
      dl_q         <= ioctl_download;
      pend_q       <= 1'b0;
      pend_cart_q  <= 1'b0;
      hdr_ok_q     <= 1'b0;
      seen_q       <= 1'b0;
      last_q       <= '0;
      cart_wr_q    <= 1'b0;
      cart_waddr_q <= '0;
      cart_wdata_q <= '0;
      bios_wr_q    <= 1'b0;
      bios_waddr_q <= '0;
      bios_wdata_q <= '0;
      is7800_q     <= 1'b0;
      size_q       <= '0;
      flags_q      <= '0;
      joy0_q       <= '0;
      joy1_q       <= '0;
      region_q     <= '0;
      save_q       <= '0;
      done_q       <= 1'b0;
      pause_q      <= 1'b1;
      ovf_q        <= 1'b0;
`ifdef A78_SIZE_CHECK_EN
      hdr_size_q   <= '0;
      mismatch_q   <= 1'b0;
`endif
    end else begin
      dl_q      <= ioctl_download;
      cart_wr_q <= 1'b0;
      bios_wr_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise || pend_q) begin
            pend_q <= 1'b0;
            if (start_cart) begin
              state_q  <= CART;
              hdr_ok_q <= 1'b0;
              seen_q   <= 1'b0;
              last_q   <= '0;
              is7800_q <= 1'b0;
              flags_q  <= '0;
              joy0_q   <= '0;
              joy1_q   <= '0;
              region_q <= '0;
              save_q   <= '0;
`ifdef A78_SIZE_CHECK_EN
              hdr_size_q <= '0;
              mismatch_q <= 1'b0;
`endif
            end else begin
              state_q <= BIOS;
            end
          end
        end
        CART: begin
          if (ioctl_wr) begin
            seen_q <= 1'b1;
            last_q <= ioctl_addr;
            if (in_range) begin
              cart_wr_q    <= 1'b1;
              cart_waddr_q <= eff_addr[17:0];
              cart_wdata_q <= ioctl_dout;
            end else begin
              ovf_q <= 1'b1;
            end
            case (ioctl_addr)
              25'd1:  hdr_ok_q <= (ioctl_dout == 8'h41);
              25'd2:  hdr_ok_q <= hdr_ok_q && (ioctl_dout == 8'h54);
              25'd3:  hdr_ok_q <= hdr_ok_q && (ioctl_dout == 8'h41);
              25'd4:  hdr_ok_q <= hdr_ok_q && (ioctl_dout == 8'h52);
              25'd5:  is7800_q <= hdr_ok_q && (ioctl_dout == 8'h49);
`ifdef A78_SIZE_CHECK_EN
              25'd49: hdr_size_q[31:24] <= ioctl_dout;
              25'd50: hdr_size_q[23:16] <= ioctl_dout;
              25'd51: hdr_size_q[15:8]  <= ioctl_dout;
              25'd52: hdr_size_q[7:0]   <= ioctl_dout;
`endif
              25'd53: flags_q[15:8] <= ioctl_dout;
              25'd54: flags_q[7:0]  <= ioctl_dout;
              25'd55: joy0_q   <= ioctl_dout;
              25'd56: joy1_q   <= ioctl_dout;
              25'd57: region_q <= ioctl_dout;
              25'd58: save_q   <= ioctl_dout;
              default: ;
            endcase
          end
          if (!ioctl_download) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        BIOS: begin
          if (ioctl_wr) begin
            bios_wr_q    <= 1'b1;
            bios_waddr_q <= ioctl_addr[11:0];
            bios_wdata_q <= ioctl_dout;
          end
          if (!ioctl_download)
            state_q <= IDLE;
        end
        FINISH: begin
          state_q <= IDLE;
          size_q  <= size_d;
          pause_q <= 1'b0;
`ifdef A78_SIZE_CHECK_EN
          mismatch_q <= is7800_q && (hdr_size_q != size_d);
`endif
          // A window opening during FINISH is remembered so it is not lost.
          if (rise) begin
            pend_q      <= 1'b1;
            pend_cart_q <= (ioctl_index != 8'd0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cart_wr       = cart_wr_q;
  assign cart_waddr    = cart_waddr_q;
  assign cart_wdata    = cart_wdata_q;
  assign bios_wr       = bios_wr_q;
  assign bios_waddr    = bios_waddr_q;
  assign bios_wdata    = bios_wdata_q;
  assign cart_is_7800  = is7800_q;
  assign cart_size     = size_q;
  assign cart_flags    = flags_q;
  assign joy0_type     = joy0_q;
  assign joy1_type     = joy1_q;
  assign cart_region   = region_q;
  assign cart_save     = save_q;
  assign load_busy     = (state_q != IDLE);
  assign load_done     = done_q;
  assign initial_pause = pause_q;
  assign addr_ovf      = ovf_q;
`ifdef A78_SIZE_CHECK_EN
  assign size_mismatch = mismatch_q;
`endif

endmodule

// File: doc/a78_loader.md
A78_LOADER -- requirements
Module: a78_loader

Interface
REQ-001 clk_sys  in  1  system clock; all logic rises on posedge clk_sys.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ioctl_download  in  1  download window active.
REQ-004 ioctl_wr  in  1  one-cycle byte-valid strobe.
REQ-005 ioctl_addr  in  25  byte offset within the downloaded file.
REQ-006 ioctl_dout  in  8  byte data.
REQ-007 ioctl_index  in  8  0 selects BIOS; any other value selects cart.
REQ-008 cart_wr / cart_waddr / cart_wdata  out  1/18/8  cart RAM write port.
REQ-009 bios_wr / bios_waddr / bios_wdata  out  1/12/8  BIOS RAM write port.
REQ-010 cart_is_7800  out  1  header bytes 1..5 equal ASCII "ATARI".
REQ-011 cart_size  out  32  payload byte count.
REQ-012 cart_flags  out  16  header bytes 53 (high) and 54 (low).
REQ-013 joy0_type, joy1_type, cart_region, cart_save  out  8 each  header bytes 55, 56, 57 and 58.
REQ-014 load_busy  out  1  high in every state except IDLE.
REQ-015 load_done  out  1  one-cycle pulse when a cart load completes.
REQ-016 initial_pause  out  1  high until the first cart load completes.
REQ-017 addr_ovf  out  1  sticky flag: a cart byte was dropped because its address was out of range.

Function
REQ-018 The FSM SHALL have four states: IDLE, CART, BIOS, FINISH.
REQ-019 IDLE SHALL go to CART on a rising edge of ioctl_download with index≠0, and to BIOS on a rising edge with index=0.
REQ-020 CART SHALL go to FINISH when ioctl_download falls; FINISH SHALL last exactly one cycle, pulse load_done in that cycle, then return to IDLE.
REQ-021 BIOS SHALL return to IDLE when ioctl_download falls; no load_done pulse and no change to cart outputs.
REQ-022 The write ports SHALL be registered: cart_wr/bios_wr assert in the cycle after ioctl_wr, with address and data captured from that same ioctl_wr cycle; the block never stalls the source.
REQ-023 In CART, bytes at addresses 1..5 SHALL be compared with "ATARI"; cart_is_7800 updates from the comparison result in the cycle after address 5 is written.
REQ-024 Cart write address SHALL be addr−128 when cart_is_7800=1 and addr≥128; otherwise addr[17:0]. Header bytes 0..127 are written at their raw address and later overwritten by payload.
REQ-025 A cart byte with effective address >18'h3FFFF SHALL NOT be written, and SHALL set addr_ovf.
REQ-026 BIOS bytes SHALL be written with bios_waddr = ioctl_addr[11:0].
REQ-027 The block SHALL track the last written address; in FINISH it SHALL load cart_size = last_addr − (cart_is_7800 ? 128 : 0) + 1 in 32-bit arithmetic.
REQ-028 A cart window with no ioctl_wr, or a 7800 file with last_addr<128, SHALL give cart_size=0.
REQ-029 The header registers and the last-address tracker SHALL clear on entry to CART.
REQ-030 initial_pause SHALL clear in FINISH and stay low until reset.
REQ-031 If ioctl_download rises and falls with no gap cycle, the FSM SHALL still pass through FINISH before accepting the next window.

Reset
REQ-032 While reset is high, the FSM SHALL go to IDLE.
REQ-033 Reset SHALL zero all outputs except initial_pause, which is set to 1.
REQ-034 A reset asserted mid-download SHALL abort the load; bytes arriving after reset releases SHALL be ignored until the next rising edge of ioctl_download.

Configuration
REQ-035 Macro A78_SIZE_CHECK_EN: when defined, the block SHALL latch header bytes 49..52 as hdr_size and add output size_mismatch (1 bit).
REQ-036 size_mismatch SHALL be set in FINISH when cart_is_7800=1 and hdr_size≠cart_size, and cleared on entry to CART and on reset.
REQ-037 When A78_SIZE_CHECK_EN is undefined, header bytes 49..52 SHALL be ignored and the size_mismatch port SHALL NOT exist.

Verification
REQ-038 Reset, then a 7800 file of 128+256 bytes with "ATARI" at bytes 1..5 and flags 16'h0102 -> cart_size=256, cart_is_7800=1, cart_flags=16'h0102, byte 128 written at cart_waddr 0, load_done pulses once, initial_pause falls.
REQ-039 Raw 2600 file of 4096 bytes, index=1 -> cart_is_7800=0, cart_size=4096, byte N written at cart_waddr N.
REQ-040 BIOS load of 4096 bytes, index=0 -> bios_wr fires 4096 times; cart outputs and initial_pause unchanged; no load_done.
REQ-041 Reset asserted at byte 200 of a cart load -> all outputs zero, initial_pause=1, remaining bytes produce no writes.
REQ-042 Raw file of 262145 bytes -> last byte dropped, addr_ovf=1.
REQ-043 With A78_SIZE_CHECK_EN defined, header size 512 and payload 256 -> size_mismatch=1; with matching sizes -> size_mismatch=0.
